mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the 8-bit/16-bit-instruction processor. It receives the decoded instruction fields (Op, Funct) and live ALU flags from the datapath, and sequences every instruction through a FETCH/DECODE/EXECUTE state machine. It drives every datapath enable and mux select, and holds the architectural NZCV flag register. Together with the datapath it forms the complete core.

## Interface
Parameters:
- none (all encodings are fixed constants in the shared package).

Ports:
- Clock  in  1  sole clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low.
- Op  in  2  instruction register bits [15:14].
- Funct  in  3  instruction register bits [13:11].
- Flags  in  4  live ALU flags {N,Z,C,V}.
- PCWrite, AdrSrc, MemWrite, IRWrite, WriteASrc, ALUSrcA, ALUSrcB, RegWrite, RegSrc  out  1 each  datapath enables and selects.
- WriteDSrc  out  2  register-file write data: 00 Result, 01 PC, 10 ReadData[7:0].
- ResultSrc  out  2  result select: 00 ALUResult, 01 shifted Rm, 10 Inst[7:0].
- ALUControl  out  3  ALU operation code.
- ShiftType  out  3  shifter code; 000 means no shift.
- FlagReg  out  4  architectural NZCV.
- State  out  3  current state, for debug.
- Halted  out  1  high in the HALT state.

## Operation
- ALU codes: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 PASSA.
- States: FETCH=0, DECODE=1, EX_DP=2, EX_SH=3, MEM_RD=4, MEM_WR=5, BRANCH=6, HALT=7.
- FETCH
  - Outputs: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=1, ALUControl=ADD, ResultSrc=00, PCWrite=1. This gives PC+=2.
  - Next state: DECODE.
- DECODE
  - No enables are asserted. The RD1/RD2 registers capture the operands.
  - Next state by Op:
    - 00 → EX_DP.
    - 01 → EX_SH.
    - 10 → MEM_RD if Funct[0]=0, else MEM_WR.
    - 11 → HALT if Funct=111, else BRANCH.
- EX_DP
  - ALUSrcA=0, ALUSrcB=0, ShiftType=000.
  - ALUControl=Funct, except Funct 111 (CMP), which uses SUB.
  - RegWrite=1 with WriteDSrc=00, ResultSrc=00, except CMP, which does not write.
  - FlagReg←Flags for every DP instruction, including CMP.
  - Next state: FETCH.
- EX_SH
  - Funct≠111: ShiftType=Funct, ResultSrc=01.
  - Funct=111 (LDI): ResultSrc=10.
  - RegWrite=1, WriteDSrc=00. FlagReg is unchanged.
  - Next state: FETCH.
- MEM_RD
  - AdrSrc=1, ALUSrcA=0, ALUControl=PASSA, ResultSrc=00. Address is Rn.
  - RegWrite=1, WriteDSrc=10.
  - Next state: FETCH.
- MEM_WR
  - Same address path as MEM_RD.
  - MemWrite=1. Store data is Rd2, made valid by RegSrc.
  - Next state: FETCH.
- BRANCH
  - Condition by Funct, evaluated on FlagReg (not on live Flags):
    - 000 AL, 001 EQ(Z), 010 NE(!Z), 011 LT(N^V), 100 GE(!(N^V)), 101 CS(C), 110 BL (always).
  - If the condition is true: PCWrite=1, ResultSrc=10. The target is absolute, Inst[7:0].
  - BL additionally sets RegWrite=1, WriteASrc=1 (R7), WriteDSrc=01. This links the already-incremented PC.
  - Next state: FETCH.
- HALT: all enables are 0. The block stays in HALT until reset.
- RegSrc=1 whenever the state is not FETCH and {Op,Funct[0]}={10,1}. It is 0 otherwise.
- Any output not listed for a state is 0.

## Timing
- Outputs are a combinational function of the registered state and the Op/Funct inputs (Moore plus decode).
- Op and Funct are ignored in FETCH.
- Every non-halting instruction takes exactly 3 cycles, including a not-taken branch.
- While Reset=0:
  - State←FETCH and FlagReg←0000 at the edge.
  - All write enables (PCWrite, MemWrite, IRWrite, RegWrite) are forced to 0 combinationally.
  - Selects are 0; Halted=0.
- On the first edge with Reset=1, the block performs FETCH at address 0.
- Reset asserted mid-instruction, including during HALT: the instruction is abandoned, no enable pulses, and the block is in FETCH next cycle.
- The FlagReg write and a same-cycle branch evaluation cannot collide, because they occur in different states.
- A branch that immediately follows CMP sees the new flags.

## Structure
- Package mc_pkg holds:
  - state encoding;
  - Op values;
  - ALU codes;
  - condition codes;
  - WriteDSrc and ResultSrc select constants;
  - LDI, CMP and HALT Funct values.
- Sub-module cond_check: combinational; inputs FlagReg and Funct; output Taken. Instantiated once.

## Test plan
- Reset held 3 cycles → all enables 0, FlagReg=0000, State=0. After release, IRWrite and PCWrite are high in the first cycle.
- Op=00 Funct=001 (SUB), Flags=1000 → State sequence 0,1,2. RegWrite=1 in state 2. FlagReg=1000 after state 2.
- CMP with Flags=0100, then Op=11 Funct=001 (EQ) → PCWrite=1, ResultSrc=10 in BRANCH. Repeating with Funct=010 (NE) → PCWrite=0.
- Op=11 Funct=110 (BL) → PCWrite=1, RegWrite=1, WriteASrc=1, WriteDSrc=01 in the same cycle.
- Op=10 Funct=001 (STR) → RegSrc=1 in DECODE and MEM_WR. MemWrite=1 and AdrSrc=1 for exactly one cycle.
- Op=11 Funct=111 → Halted=1, all enables 0 for 10 cycles. Reset low for 1 cycle → State=0, Halted=0.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle control unit
// Holds the FSM state encoding, Op values, ALU codes, branch condition codes,
// write-data/result select constants and the special Funct values.
package mc_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EX_DP  = 3'd2,
        S_EX_SH  = 3'd3,
        S_MEM_RD = 3'd4,
        S_MEM_WR = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_SH  = 2'b01;
    localparam logic [1:0] OP_MEM = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_EOR   = 3'b100;
    localparam logic [2:0] ALU_PASSA = 3'b101;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_CS = 3'b101;
    localparam logic [2:0] COND_BL = 3'b110;

    localparam logic [1:0] WD_RESULT = 2'b00;
    localparam logic [1:0] WD_PC     = 2'b01;
    localparam logic [1:0] WD_RDATA  = 2'b10;

    localparam logic [1:0] RS_ALU   = 2'b00;
    localparam logic [1:0] RS_SHIFT = 2'b01;
    localparam logic [1:0] RS_IMM   = 2'b10;

    localparam logic [2:0] FN_LDI  = 3'b111;
    localparam logic [2:0] FN_CMP  = 3'b111;
    localparam logic [2:0] FN_HALT = 3'b111;
endpackage

// File: rtl/cond_check.sv
// cond_check: branch condition evaluation on the architectural NZCV register
// Ports: FlagReg (NZCV in), Funct (condition code in), Taken (condition true out).
module cond_check
    import mc_pkg::*;
(
    input  logic [3:0] FlagReg,
    input  logic [2:0] Funct,
    output logic       Taken
);
    logic n, z, c, v;
    assign {n, z, c, v} = FlagReg;
    always_comb begin
        Taken = 1'b0;
        case (Funct)
            COND_AL: Taken = 1'b1;
            COND_EQ: Taken = z;
            COND_NE: Taken = !z;
            COND_LT: Taken = n ^ v;
            COND_GE: Taken = !(n ^ v);
            COND_CS: Taken = c;
            COND_BL: Taken = 1'b1;
            default: Taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: FETCH/DECODE/EXECUTE sequencer and NZCV flag register
// Ports: Clock, Reset (sync, active-low); Op/Funct decoded instruction fields;
// Flags live ALU NZCV; datapath enables/selects out; FlagReg architectural NZCV;
// State current FSM state; Halted high in HALT.
module mc_controller
    import mc_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] Op,
    input  logic [2:0] Funct,
    input  logic [3:0] Flags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       WriteASrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       RegWrite,
    output logic       RegSrc,
    output logic [1:0] WriteDSrc,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [2:0] ShiftType,
    output logic [3:0] FlagReg,
    output logic [2:0] State,
    output logic       Halted
);
    state_t     state_q, state_d;
    logic [3:0] flag_q;
    logic       taken;

    cond_check u_cond (
        .FlagReg(flag_q),
        .Funct  (Funct),
        .Taken  (taken)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            flag_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (state_q == S_EX_DP)
                flag_q <= Flags;
        end
    end

    // Everything is decoded only while out of reset, so an asserted Reset
    // suppresses every enable and select in the same cycle.
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        WriteASrc  = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        RegWrite   = 1'b0;
        RegSrc     = 1'b0;
        WriteDSrc  = WD_RESULT;
        ResultSrc  = RS_ALU;
        ALUControl = ALU_ADD;
        ShiftType  = 3'b000;
        Halted     = 1'b0;
        if (Reset) begin
            case (state_q)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    ALUSrcA = 1'b1;
                    ALUSrcB = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE:
                    state_d = Op == OP_DP  ? S_EX_DP :
                              Op == OP_SH  ? S_EX_SH :
                              Op == OP_MEM ? (Funct[0] ? S_MEM_WR : S_MEM_RD) :
                              (Funct == FN_HALT ? S_HALT : S_BRANCH);
                S_EX_DP: begin
                    ALUControl = Funct == FN_CMP ? ALU_SUB : Funct;
                    RegWrite   = Funct != FN_CMP;
                    state_d    = S_FETCH;
                end
                S_EX_SH: begin
                    ShiftType = Funct == FN_LDI ? 3'b000 : Funct;
                    ResultSrc = Funct == FN_LDI ? RS_IMM : RS_SHIFT;
                    RegWrite  = 1'b1;
                    state_d   = S_FETCH;
                end
                S_MEM_RD: begin
                    AdrSrc     = 1'b1;
                    ALUControl = ALU_PASSA;
                    RegWrite   = 1'b1;
                    WriteDSrc  = WD_RDATA;
                    state_d    = S_FETCH;
                end
                S_MEM_WR: begin
                    AdrSrc     = 1'b1;
                    ALUControl = ALU_PASSA;
                    MemWrite   = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    PCWrite   = taken;
                    ResultSrc = taken ? RS_IMM : RS_ALU;
                    // BL links the PC already advanced by FETCH into R7.
                    RegWrite  = taken && Funct == COND_BL;
                    WriteASrc = taken && Funct == COND_BL;
                    WriteDSrc = taken && Funct == COND_BL ? WD_PC : WD_RESULT;
                    state_d   = S_FETCH;
                end
                S_HALT: begin
                    Halted  = 1'b1;
                    state_d = S_HALT;
                end
                default: state_d = S_FETCH;
            endcase
            // Store data comes from Rd, so the register-file read port is
            // steered from DECODE onwards to have it ready in MEM_WR.
            RegSrc = state_q != S_FETCH && Op == OP_MEM && Funct[0];
        end
    end

    assign FlagReg = flag_q;
    assign State   = state_q;
endmodule
